// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // Little-endian lane merge: byte for lane k lands in bits [8k+7:8k].
  function automatic logic [31:0] lane_merge(input logic [31:0]       acc,
                                             input logic [7:0]        data,
                                             input logic [LANE_W-1:0] lane);
    return acc | ({24'd0, data} << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; emits a one-cycle word strobe.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_take_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0] lane_q;
  logic [31:0]       acc_q;
  logic [31:0]       word_q;
  logic              word_valid_q;
  logic [31:0]       merged_d;

  // Lanes above the current one are always zero in acc_q, so a short last word is zero-padded.
  assign merged_d     = lane_merge(acc_q, data_i, lane_q);
  assign word_take_o  = accept_i & ((lane_q == LANE_W'(BYTES_PER_WORD - 1)) | last_i);
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lane_q       <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        lane_q <= '0;
        acc_q  <= '0;
      end else if (word_take_o) begin
        word_q       <= merged_d;
        word_valid_q <= 1'b1;
        lane_q       <= '0;
        acc_q        <= '0;
      end else if (accept_i) begin
        acc_q  <= merged_d;
        lane_q <= lane_q + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams an image into instruction memory and holds the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  imem_loader_if.slave      bus_if,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  state_e            state_q;
  logic              in_ready_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic              cpu_rstn_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   word_count_q;

  logic              accept;
  logic              full;
  logic              start_ok;
  logic              word_take;
  logic              word_valid;
  logic [DATA_W-1:0] word_w;

  assign accept   = in_ready_q & bus_if.in_valid;
  assign full     = (word_count_q == {1'b1, {ADDR_W{1'b0}}});
  assign start_ok = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));

  // A byte arriving when memory is already full is dropped, so it never reaches the packer.
  imem_byte_packer u_packer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (start_ok),
    .accept_i     (accept & ~full),
    .data_i       (bus_if.in_data),
    .last_i       (bus_if.in_last),
    .word_take_o  (word_take),
    .word_valid_o (word_valid),
    .word_o       (word_w)
  );

  assign bus_if.in_ready = in_ready_q;
  assign bus_if.im_we    = word_valid;
  assign bus_if.im_addr  = im_addr_q;
  assign bus_if.im_wdata = word_w;
  assign cpu_rstn_o      = cpu_rstn_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign word_count_o    = word_count_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      im_addr_q    <= '0;
      cpu_rstn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q      <= ST_LOAD;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            cpu_rstn_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            im_addr_q    <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (full) begin
              state_q    <= ST_ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              // Address and count move with the handshake so they line up with the write pulse.
              if (word_take) begin
                im_addr_q    <= word_count_q[ADDR_W-1:0];
                word_count_q <= word_count_q + (ADDR_W+1)'(1);
              end
              if (bus_if.in_last) begin
                state_q    <= ST_FLUSH;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_FLUSH: begin
          state_q    <= ST_DONE;
          busy_q     <= 1'b0;
          cpu_rstn_q <= 1'b1;
          done_q     <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a 256-word instance and a 4-word instance for overflow.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rstn;
  logic       startCmd;
  logic       tbValid;
  logic       tbLast;
  logic [7:0] tbData;
  bit         useSmall;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) ifA ();
  imem_loader_if #(.ADDR_W(2)) ifB ();

  logic       cpuRstnA, busyA, doneA, errA;
  logic [8:0] wcA;
  logic       cpuRstnB, busyB, doneB, errB;
  logic [2:0] wcB;

  assign ifA.in_valid = tbValid & ~useSmall;
  assign ifA.in_data  = tbData;
  assign ifA.in_last  = tbLast;
  assign ifB.in_valid = tbValid & useSmall;
  assign ifB.in_data  = tbData;
  assign ifB.in_last  = tbLast;

  imem_loader #(.ADDR_W(8)) dutA (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (startCmd & ~useSmall),
    .bus_if       (ifA.slave),
    .cpu_rstn_o   (cpuRstnA),
    .busy_o       (busyA),
    .done_o       (doneA),
    .err_o        (errA),
    .word_count_o (wcA)
  );

  imem_loader #(.ADDR_W(2)) dutB (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (startCmd & useSmall),
    .bus_if       (ifB.slave),
    .cpu_rstn_o   (cpuRstnB),
    .busy_o       (busyB),
    .done_o       (doneB),
    .err_o        (errB),
    .word_count_o (wcB)
  );

  logic       obsReady, obsWe, obsCpu, obsBusy, obsDone, obsErr;
  logic [8:0] obsCount;

  assign obsReady = useSmall ? ifB.in_ready : ifA.in_ready;
  assign obsWe    = useSmall ? ifB.im_we    : ifA.im_we;
  assign obsCpu   = useSmall ? cpuRstnB     : cpuRstnA;
  assign obsBusy  = useSmall ? busyB        : busyA;
  assign obsDone  = useSmall ? doneB        : doneA;
  assign obsErr   = useSmall ? errB         : errA;
  assign obsCount = useSmall ? {6'd0, wcB}  : wcA;

  // Instruction-memory stand-ins: each write strobe is captured at the edge that ends it.
  logic [31:0] memA [256];
  logic [31:0] memB [4];
  int          writesA = 0;
  int          writesB = 0;

  always @(posedge clk) begin
    if (ifA.im_we === 1'b1) begin
      memA[ifA.im_addr] = ifA.im_wdata;
      writesA++;
    end
    if (ifB.im_we === 1'b1) begin
      memB[ifB.im_addr] = ifB.im_wdata;
      writesB++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference image: word i holds bytes 4i..4i+3 little-endian, missing bytes read as zero.
  function automatic logic [31:0] modelWord(input logic [7:0] img[$], input int idx);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) begin
      int p = 4 * idx + k;
      if (p < img.size()) w = w + (32'(img[p]) << (8 * k));
    end
    return w;
  endfunction

  function automatic int modelWords(input int nBytes);
    return (nBytes + 3) / 4;
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 256; i++) memA[i] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) memB[i] = 32'hDEADBEEF;
    writesA = 0;
    writesB = 0;
  endtask

  task automatic pulseStart();
    startCmd = 1'b1;
    @(negedge clk);
    startCmd = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] img[$], input bit withLast, input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      int n = 0;
      if (gaps) begin
        tbValid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      tbValid = 1'b1;
      tbData  = img[i];
      tbLast  = withLast && (i == img.size() - 1);
      while (obsReady !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (obsReady !== 1'b1) begin
        checkOutput("handshake_timeout", 64'(obsReady), 64'd1);
        break;
      end
      @(negedge clk);
    end
    tbValid = 1'b0;
    tbLast  = 1'b0;
  endtask

  task automatic checkImage(input string tag, input logic [7:0] img[$]);
    for (int i = 0; i < modelWords(img.size()); i++)
      checkOutput($sformatf("%s_w%0d", tag, i), 64'(useSmall ? memB[i] : memA[i]), 64'(modelWord(img, i)));
  endtask

  // Called at the first falling edge after the in_last handshake.
  task automatic finishLoad(input string tag, input logic [7:0] img[$]);
    checkOutput({tag, "_flush_ready"}, 64'(obsReady), 64'd0);
    checkOutput({tag, "_flush_we"}, 64'(obsWe), 64'd1);
    checkOutput({tag, "_flush_done"}, 64'(obsDone), 64'd0);
    checkOutput({tag, "_flush_cpu"}, 64'(obsCpu), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, 64'(obsDone), 64'd1);
    checkOutput({tag, "_cpu"}, 64'(obsCpu), 64'd1);
    checkOutput({tag, "_busy"}, 64'(obsBusy), 64'd0);
    checkOutput({tag, "_err"}, 64'(obsErr), 64'd0);
    checkOutput({tag, "_count"}, 64'(obsCount), 64'(modelWords(img.size())));
    checkOutput({tag, "_writes"}, 64'(useSmall ? writesB : writesA), 64'(modelWords(img.size())));
    checkImage(tag, img);
  endtask

  logic [7:0] img[$];
  logic [7:0] prev[$];
  logic [7:0] part[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    useSmall = 1'b0;
    tbValid  = 1'b0;
    tbLast   = 1'b0;
    tbData   = 8'h00;
    startCmd = 1'b0;
    rstn     = 1'b0;
    clearMem();
    repeat (2) @(negedge clk);

    // Reset and start together: reset must win.
    startCmd = 1'b1;
    @(negedge clk);
    startCmd = 1'b0;
    checkOutput("rst_ready", 64'(ifA.in_ready), 64'd0);
    checkOutput("rst_we", 64'(ifA.im_we), 64'd0);
    checkOutput("rst_addr", 64'(ifA.im_addr), 64'd0);
    checkOutput("rst_wdata", 64'(ifA.im_wdata), 64'd0);
    checkOutput("rst_cpu", 64'(cpuRstnA), 64'd0);
    checkOutput("rst_busy", 64'(busyA), 64'd0);
    checkOutput("rst_done", 64'(doneA), 64'd0);
    checkOutput("rst_err", 64'(errA), 64'd0);
    checkOutput("rst_count", 64'(wcA), 64'd0);
    checkOutput("rstB_err", 64'(errB), 64'd0);
    checkOutput("rstB_count", 64'(wcB), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 64'(ifA.in_ready), 64'd0);
    checkOutput("idle_busy", 64'(busyA), 64'd0);

    // Two-instruction program.
    img = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    pulseStart();
    checkOutput("t1_busy", 64'(obsBusy), 64'd1);
    checkOutput("t1_ready", 64'(obsReady), 64'd1);
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t1", img);
    checkOutput("t1_addr0", 64'(memA[0]), 64'h00000513);
    checkOutput("t1_addr1", 64'(memA[1]), 64'h00100593);

    // Restart from DONE with a partial last word.
    clearMem();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    pulseStart();
    checkOutput("t2_cpu_fall", 64'(obsCpu), 64'd0);
    checkOutput("t2_done_clr", 64'(obsDone), 64'd0);
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t2", img);
    checkOutput("t2_addr1", 64'(memA[1]), 64'h00002211);
    checkOutput("t2_addr2_untouched", 64'(memA[2]), 64'hDEADBEEF);

    // Random 12 bytes, gapless then with random valid gaps.
    img = {};
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t3_gapless", img);
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b1, 1'b1);
    finishLoad("t3_gaps", img);

    // in_last on the very first byte.
    img = '{8'($urandom_range(1, 255))};
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t4_single", img);

    // Short image over a longer one overwrites only address 0.
    prev = {};
    for (int i = 0; i < 8; i++) prev.push_back(8'($urandom));
    clearMem();
    pulseStart();
    applyStimulus(prev, 1'b1, 1'b0);
    finishLoad("t5_first", prev);
    writesA = 0;
    img = {};
    for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
    pulseStart();
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t5_over", img);
    checkOutput("t5_addr1_kept", 64'(memA[1]), 64'(modelWord(prev, 1)));

    // Reset two bytes into word 3.
    img = {};
    for (int i = 0; i < 14; i++) img.push_back(8'($urandom));
    part = img[0:11];
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t6_ready", 64'(ifA.in_ready), 64'd0);
    checkOutput("t6_we", 64'(ifA.im_we), 64'd0);
    checkOutput("t6_addr", 64'(ifA.im_addr), 64'd0);
    checkOutput("t6_wdata", 64'(ifA.im_wdata), 64'd0);
    checkOutput("t6_busy", 64'(busyA), 64'd0);
    checkOutput("t6_count", 64'(wcA), 64'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_writes", 64'(writesA), 64'd3);
    checkOutput("t6_addr3_untouched", 64'(memA[3]), 64'hDEADBEEF);
    checkImage("t6", part);

    // Exactly full memory with in_last on the final byte.
    img = {};
    for (int i = 0; i < 1024; i++) img.push_back(8'($urandom));
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t7_full", img);

    // Overflow on the 4-word instance.
    useSmall = 1'b1;
    img = {};
    for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
    part = img[0:15];
    clearMem();
    pulseStart();
    applyStimulus(img, 1'b0, 1'b0);
    checkOutput("t8_err", 64'(obsErr), 64'd1);
    checkOutput("t8_ready", 64'(obsReady), 64'd0);
    checkOutput("t8_cpu", 64'(obsCpu), 64'd0);
    checkOutput("t8_done", 64'(obsDone), 64'd0);
    checkOutput("t8_count", 64'(obsCount), 64'd4);
    @(negedge clk);
    checkOutput("t8_writes", 64'(writesB), 64'd4);
    checkImage("t8", part);
    prev = part;
    writesB = 0;
    pulseStart();
    checkOutput("t8_err_clr", 64'(obsErr), 64'd0);
    checkOutput("t8_count_clr", 64'(obsCount), 64'd0);
    img = {};
    for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
    applyStimulus(img, 1'b1, 1'b0);
    finishLoad("t8_reload", img);
    checkOutput("t8_addr1_kept", 64'(memB[1]), 64'(modelWord(prev, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the single-cycle RISC-V computer.
- Accepts a byte stream over a valid/ready interface and packs it little-endian into 32-bit words.
- Writes each word into instruction memory at incrementing word addresses, holding the CPU in reset until the image is complete.
- Writes the same image a simulation bench otherwise preloads, so hardware can boot without file loading.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth 2**ADDR_W = 256 words).
- DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a new load from word address 0
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_last  in  1  marks the final byte of the image; qualified by in_valid
- in_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  ADDR_W  word address of the write
- im_wdata  out  32  word to write
- cpu_rstn  out  1  active-low reset to the CPU; low while loading
- busy  out  1  high in LOAD/FLUSH
- done  out  1  sticky; image loaded and CPU released
- err  out  1  sticky; image overflowed memory depth
- word_count  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_rstn=0, busy=0, done=0, err=0, word_count=0.
  - Byte-lane index cleared.
  - Applies mid-load as well; words already written stay in memory.
- States:
  - IDLE: in_ready=0. start -> LOAD, clearing lane, word_count and address.
  - LOAD: in_ready=1; a byte is accepted when in_valid and in_ready.
    - Byte k (k=0..3) goes to bits [8k+7:8k].
    - Accepting lane 3, or in_last at any lane, moves the word to the write register.
    - Cycle after that handshake: im_we=1 for exactly one cycle, with im_addr = word_count (pre-increment) and im_wdata = packed word, unfilled upper lanes zero.
    - word_count increments in the same cycle as im_we.
    - in_ready stays 1 during the write pulse, so back-to-back bytes are never stalled.
  - in_last accepted -> FLUSH:
    - in_ready=0; the final write pulse issues.
    - Next cycle -> DONE.
  - DONE:
    - cpu_rstn=1, done=1 from the first DONE cycle; exactly 2 cycles after the in_last handshake.
    - in_ready=0; state holds.
  - ERR:
    - Entered when a byte is accepted while word_count == 2**ADDR_W (memory full).
    - That byte is dropped; no write occurs.
    - err=1, in_ready=0, cpu_rstn stays 0.
- start handling:
  - In DONE or ERR: clears done/err, drives cpu_rstn=0 next cycle, re-enters LOAD.
  - In LOAD/FLUSH: ignored.
- Boundary cases:
  - in_last on lane 3: a single write; no empty extra word.
  - in_last on the very first byte: one word, zero-padded.
  - Exactly 2**ADDR_W full words with in_last on the final byte: completes to DONE, no err.
  - in_valid low: no state change; partial lane contents are held indefinitely.
  - Reset and start in the same cycle: reset wins.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, LOAD, FLUSH, DONE, ERR.
  - BYTES_PER_WORD=4.
  - Lane-index width constant.
- One natural sub-module: imem_byte_packer.
  - Contains the lane counter, little-endian shift/merge and zero-pad on last.
  - Outputs word_valid/word for one cycle.
- The top holds the FSM, address/count and CPU reset control.

Test Plan:
- start; 8 bytes 13 05 00 00 93 05 10 00, in_last on the 8th:
  - writes addr0=0x00000513 and addr1=0x00100593.
  - word_count=2; cpu_rstn rises and done=1 two cycles after the last handshake.
- 6 bytes AA BB CC DD 11 22, in_last on 0x22: addr1=0x00002211, exactly 2 im_we pulses.
- in_valid toggled 1-0-0-1 with random gaps across 12 bytes: data identical to the gapless run; 3 writes, no duplicate strobes.
- ADDR_W=2; 17 bytes, no in_last:
  - 4 writes occur, then err=1 on the 17th byte.
  - in_ready=0, cpu_rstn stays 0.
  - start then reloads from addr 0 with err cleared.
- rstn low for 1 cycle after 2 bytes of word 3:
  - all outputs at reset values next cycle; no write for the partial word.
  - words 0-2 intact.
- After DONE, start:
  - cpu_rstn falls next cycle, done clears.
  - new 4-byte image overwrites addr0 only; word_count=1.
